// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcodes and sizing defaults for the SPI RAM
package spi_ram_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int MEM_DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } RAM_OP_e;

endpackage

// File: rtl/spi_ram_if.sv
// rtl/spi_ram_if.sv - command/response link between SPI slave and RAM
interface spi_ram_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
);
    logic [ADDR_SIZE+1:0] din;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] dout;
    logic                 tx_valid;
    logic                 seq_err;

    modport master (
        output din, rx_valid,
        input  dout, tx_valid, seq_err
    );

    modport slave (
        input  din, rx_valid,
        output dout, tx_valid, seq_err
    );
endinterface

// File: rtl/spi_ram_array.sv
// rtl/spi_ram_array.sv - synchronous-write, registered-read storage array
module spi_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [ADDR_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE-1:0] rdata
);
    logic [ADDR_SIZE-1:0] r_mem [MEM_DEPTH];

    // Storage is deliberately left out of reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end
endmodule

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - command decode, address registers and sequencing checks
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_ram_if.slave bus
);
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_wr_armed;
    logic                 r_rd_armed;
    logic                 r_tx_valid;
    logic                 r_seq_err;

    RAM_OP_e              w_op;
    logic [ADDR_SIZE-1:0] w_payload;
    logic                 w_we;
    logic                 w_re;
    logic                 w_seq_err;
    logic [ADDR_SIZE-1:0] w_rdata;

    assign w_op      = RAM_OP_e'(bus.din[ADDR_SIZE+1:ADDR_SIZE]);
    assign w_payload = bus.din[ADDR_SIZE-1:0];

    always_comb begin
        w_we      = 1'b0;
        w_re      = 1'b0;
        w_seq_err = 1'b0;
        if (bus.rx_valid) begin
            case (w_op)
                WR_DATA: begin
                    w_we      = r_wr_armed;
                    w_seq_err = !r_wr_armed;
                end
                RD_DATA: begin
                    w_re      = r_rd_armed;
                    w_seq_err = !r_rd_armed;
                end
                default: ;
            endcase
        end
    end

    // Address width equals log2(MEM_DEPTH), so the increment wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
            r_tx_valid <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_tx_valid <= w_re;
            r_seq_err  <= w_seq_err;
            if (bus.rx_valid) begin
                case (w_op)
                    WR_ADDR: begin
                        r_wr_addr  <= w_payload;
                        r_wr_armed <= 1'b1;
                    end
                    WR_DATA: begin
                        if (w_we && AUTO_INC) begin
                            r_wr_addr <= r_wr_addr + ADDR_ONE;
                        end
                    end
                    RD_ADDR: begin
                        r_rd_addr  <= w_payload;
                        r_rd_armed <= 1'b1;
                    end
                    RD_DATA: begin
                        if (w_re && AUTO_INC) begin
                            r_rd_addr <= r_rd_addr + ADDR_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (r_wr_addr),
        .wdata (w_payload),
        .re    (w_re),
        .raddr (r_rd_addr),
        .rdata (w_rdata)
    );

    assign bus.dout     = w_rdata;
    assign bus.tx_valid = r_tx_valid;
    assign bus.seq_err  = r_seq_err;
endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - scoreboard bench for spi_ram, plain and auto-increment variants
module tb_spi_ram;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ram_if #(.ADDR_SIZE(8)) bus0 ();
    spi_ram_if #(.ADDR_SIZE(8)) bus1 ();

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // tv=1: a tx_valid response carrying d; tv=0: a seq_err with dout held at d
    typedef struct packed {
        logic       tv;
        logic [7:0] d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    logic [7:0] m_mem  [2][256];
    int         m_wa   [2];
    int         m_ra   [2];
    logic [7:0] m_dout [2];
    bit         m_warm [2];
    bit         m_rarm [2];

    task automatic push(input int k, input logic tv, input logic [7:0] d);
        exp_t e;
        e.tv = tv;
        e.d  = d;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wa[k] = 0; m_ra[k] = 0; m_dout[k] = 8'h00;
            m_warm[k] = 1'b0; m_rarm[k] = 1'b0;
        end
    endtask

    task automatic model_cmd(input int k, input logic [1:0] op, input logic [7:0] p);
        bit auto_inc;
        auto_inc = (k == 1);
        case (op)
            2'b00: begin m_wa[k] = int'(p); m_warm[k] = 1'b1; end
            2'b01: begin
                if (m_warm[k]) begin
                    m_mem[k][m_wa[k]] = p;
                    if (auto_inc) m_wa[k] = (m_wa[k] + 1) % 256;
                end else begin
                    push(k, 1'b0, m_dout[k]);
                end
            end
            2'b10: begin m_ra[k] = int'(p); m_rarm[k] = 1'b1; end
            default: begin
                if (m_rarm[k]) begin
                    m_dout[k] = m_mem[k][m_ra[k]];
                    push(k, 1'b1, m_dout[k]);
                    if (auto_inc) m_ra[k] = (m_ra[k] + 1) % 256;
                end else begin
                    push(k, 1'b0, m_dout[k]);
                end
            end
        endcase
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] p);
        @(negedge clk);
        bus0.din = {op, p}; bus0.rx_valid = 1'b1;
        bus1.din = {op, p}; bus1.rx_valid = 1'b1;
        model_cmd(0, op, p);
        model_cmd(1, op, p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus0.rx_valid = 1'b0;
            bus1.rx_valid = 1'b0;
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus0.rx_valid = 1'b0;
        bus1.rx_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_val("reset_dout0", bus0.dout, 8'h00);
        check_val("reset_tx_valid0", {7'd0, bus0.tx_valid}, 8'h00);
        check_val("reset_seq_err0", {7'd0, bus0.seq_err}, 8'h00);
        check_val("reset_dout1", bus1.dout, 8'h00);
        check_val("reset_tx_valid1", {7'd0, bus1.tx_valid}, 8'h00);
        check_val("reset_seq_err1", {7'd0, bus1.seq_err}, 8'h00);
        mon_en = 1'b1;
    endtask

    task automatic mon(input int k, input logic tv, input logic se, input logic [7:0] d);
        exp_t e;
        int   n;
        if (tv || se) begin
            checks++;
            n = (k == 0) ? q0.size() : q1.size();
            if (tv && se) begin
                errors++;
                $display("FAIL dut%0d_both_pulses: tx_valid=%b seq_err=%b expected exclusive", k, tv, se);
                if (n > 0) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end else if (n == 0) begin
                errors++;
                $display("FAIL dut%0d_unexpected: tx_valid=%b seq_err=%b dout=%h expected no response", k, tv, se, d);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                if (e.tv !== tv || e.d !== d) begin
                    errors++;
                    $display("FAIL dut%0d_response: tx_valid=%b dout=%h expected tx_valid=%b dout=%h",
                             k, tv, d, e.tv, e.d);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon(0, bus0.tx_valid, bus0.seq_err, bus0.dout);
            mon(1, bus1.tx_valid, bus1.seq_err, bus1.dout);
        end
    end

    initial begin
        logic [7:0] hold0;
        logic [7:0] hold1;
        bus0.din = '0; bus0.rx_valid = 1'b0;
        bus1.din = '0; bus1.rx_valid = 1'b0;
        model_reset();
        idle(2);
        do_reset();

        // RD_DATA before any address
        cmd(2'b11, 8'h00);
        idle(2);

        // Fill every location so later reads have a known model value
        for (int a = 0; a < 256; a++) begin
            cmd(2'b00, 8'(a));
            cmd(2'b01, 8'(a) ^ 8'h5A);
        end
        idle(1);

        // Basic write then read back
        cmd(2'b00, 8'h3C); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h3C); cmd(2'b11, 8'h00);
        idle(2);

        // Unarmed write after reset must not touch memory
        do_reset();
        cmd(2'b01, 8'h11);
        cmd(2'b00, 8'h00); cmd(2'b10, 8'h00); cmd(2'b11, 8'h00);
        idle(2);

        // Wraparound across the top of the address space
        cmd(2'b00, 8'hFF); cmd(2'b01, 8'h01); cmd(2'b01, 8'h02);
        cmd(2'b10, 8'hFF); cmd(2'b11, 8'h00); cmd(2'b11, 8'h00);
        idle(2);

        // Reset discards latched addresses
        cmd(2'b00, 8'h10); cmd(2'b01, 8'h77); cmd(2'b10, 8'h10);
        idle(1);
        do_reset();
        cmd(2'b11, 8'h00); cmd(2'b01, 8'h22);
        idle(2);

        // Randomized command mix
        for (int i = 0; i < 400; i++) begin
            cmd(2'($urandom_range(0, 3)), 8'($urandom));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(2);

        // Idle bus with toggling din
        hold0 = m_dout[0];
        hold1 = m_dout[1];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus0.rx_valid = 1'b0; bus0.din = 10'($urandom);
            bus1.rx_valid = 1'b0; bus1.din = 10'($urandom);
        end
        idle(2);
        check_val("idle_dout0", bus0.dout, hold0);
        check_val("idle_dout1", bus1.dout, hold1);

        idle(3);
        check_val("pending_q0", 8'(q0.size()), 8'd0);
        check_val("pending_q1", 8'(q1.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
